// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and command-side signal bundle for uart_cmd_ctrl.
// master = the frame controller, slave = its environment (uart_rx + crypto selector).
interface uart_cmd_ctrl_if #(
    parameter int MAX_LEN = 32
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          rx_ack;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_op;
    logic [LW-1:0] cmd_len;
    logic [AW-1:0] pay_raddr;
    logic [7:0]    pay_rdata;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic          busy;

    modport master (
        input  rx_data, rx_ready, cmd_ready, pay_raddr,
        output rx_ack, cmd_valid, cmd_op, cmd_len, pay_rdata, err_pulse, err_code, busy
    );

    modport slave (
        output rx_data, rx_ready, cmd_ready, pay_raddr,
        input  rx_ack, cmd_valid, cmd_op, cmd_len, pay_rdata, err_pulse, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame parser: SYNC, opcode, length, payload, XOR checksum -> validated command
// with backpressure, random-access payload read, and error/timeout strobes.
module uart_cmd_ctrl #(
    parameter int         MAX_LEN        = 32,
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    uart_cmd_ctrl_if.master bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_OP, S_LEN, S_PAY, S_CHK, S_ISSUE} state_e;
    typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_CHK = 2'd1, ERR_LEN = 2'd2, ERR_TMO = 2'd3} err_e;

    state_e        state_q, state_d;
    err_e          err_d, err_code_q;
    logic          rx_ack_q, err_pulse_q;
    logic [7:0]    op_q, chk_q, cmd_op_q;
    logic [LW-1:0] len_q, idx_q, cmd_len_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    pay_mem [MAX_LEN];

    logic take, in_frame, tmo, chk_ok, last_pay;

    // The ack guard stops a byte being taken twice while uart_rx drops rx_ready.
    assign take     = bus.rx_ready && !rx_ack_q && (state_q != S_ISSUE);
    assign in_frame = state_q inside {S_OP, S_LEN, S_PAY, S_CHK};
    assign tmo      = in_frame && !take && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign chk_ok   = (bus.rx_data == chk_q);
    assign last_pay = (idx_q == len_q - LW'(1));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
        state_d = state_q;
        err_d   = ERR_NONE;
        case (state_q)
            S_IDLE:  if (take && bus.rx_data == SYNC_BYTE) state_d = S_OP;
            S_OP:    if (take) state_d = S_LEN;
            S_LEN: if (take) begin
                if (bus.rx_data > 8'(MAX_LEN)) begin
                    state_d = S_IDLE;
                    err_d   = ERR_LEN;
                end else if (bus.rx_data == 8'd0) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_PAY;
                end
            end
            S_PAY:   if (take && last_pay) state_d = S_CHK;
            S_CHK: if (take) begin
                if (chk_ok) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                    err_d   = ERR_CHK;
                end
            end
            S_ISSUE: if (bus.cmd_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A byte arriving on the expiry cycle wins: tmo already excludes take.
        if (tmo) begin
            state_d = S_IDLE;
            err_d   = ERR_TMO;
        end
    end

    always_comb begin
        bus.rx_ack    = rx_ack_q;
        bus.cmd_valid = (state_q == S_ISSUE);
        bus.busy      = (state_q != S_IDLE);
        bus.cmd_op    = cmd_op_q;
        bus.cmd_len   = cmd_len_q;
        bus.err_pulse = err_pulse_q;
        bus.err_code  = err_code_q;
        bus.pay_rdata = pay_mem[bus.pay_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ack_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            cmd_op_q    <= '0;
            cmd_len_q   <= '0;
            op_q        <= '0;
            chk_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
        end else begin
            rx_ack_q    <= take;
            err_pulse_q <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) err_code_q <= err_d;

            if (take || tmo || !in_frame) timer_q <= '0;
            else                          timer_q <= timer_q + TW'(1);

            if (take) begin
                case (state_q)
                    S_OP: begin
                        op_q  <= bus.rx_data;
                        chk_q <= bus.rx_data;
                    end
                    S_LEN: begin
                        chk_q <= chk_q ^ bus.rx_data;
                        len_q <= LW'(bus.rx_data);
                        idx_q <= '0;
                    end
                    S_PAY: begin
                        chk_q <= chk_q ^ bus.rx_data;
                        idx_q <= idx_q + LW'(1);
                    end
                    S_CHK: if (chk_ok) begin
                        cmd_op_q  <= op_q;
                        cmd_len_q <= len_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the payload RAM has no reset; its contents only matter while cmd_valid is high.
    always_ff @(posedge clk) begin
        if (take && state_q == S_PAY) pay_mem[idx_q[AW-1:0]] <= bus.rx_data;
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames from the test plan
// plus randomized frames checked against a frame-level reference model.
module tb_uart_cmd_ctrl;
    localparam int MAX_LEN = 32;
    localparam int TMO     = 100;
    localparam int AW      = $clog2(MAX_LEN);
    localparam int K_NONE  = 0;
    localparam int K_CMD   = 1;
    localparam int K_ERR   = 2;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_cmd_ctrl #(
        .MAX_LEN(MAX_LEN),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Event monitor: counts ack and error pulses, records cycles and the last code.
    int unsigned cyc = 0, ack_cnt = 0, err_cnt = 0, err_wide = 0, take_cyc = 0, err_cyc = 0;
    logic [1:0]  last_code = 2'd0;
    logic        err_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_ack === 1'b1) begin
            ack_cnt  <= ack_cnt + 1;
            take_cyc <= cyc;
        end
        if (bus.err_pulse === 1'b1) begin
            err_cnt   <= err_cnt + 1;
            last_code <= bus.err_code;
            err_cyc   <= cyc;
            if (err_prev) err_wide <= err_wide + 1;
        end
        err_prev <= (bus.err_pulse === 1'b1);
    end

    // Frame-level reference: hunt sync, then apply length/checksum rules.
    function automatic void model(input bq_t q, output int kind, output logic [1:0] code,
                                  output logic [7:0] op, output int len, output int pstart);
        int s;
        logic [7:0] x;
        s = -1;
        kind = K_NONE; code = 2'd0; op = 8'd0; len = 0; pstart = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] == 8'hA5) begin
                s = i;
                break;
            end
        end
        if (s < 0 || q.size() < s + 3) return;
        op     = q[s+1];
        len    = int'(q[s+2]);
        pstart = s + 3;
        if (len > MAX_LEN) begin
            kind = K_ERR;
            code = 2'd2;
            return;
        end
        if (q.size() < s + 4 + len) return;
        x = 8'd0;
        for (int i = s + 1; i < s + 3 + len; i++) x ^= q[i];
        if (q[s+3+len] == x) kind = K_CMD;
        else begin
            kind = K_ERR;
            code = 2'd1;
        end
    endfunction

    // uart_rx emulation: rx_ready held through the ack cycle, dropped afterwards.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (bus.rx_ack !== 1'b1 && n < 20);
        check("rx_ack_seen", 32'(bus.rx_ack), 32'd1);
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("rx_ack_one_cycle", 32'(bus.rx_ack), 32'd0);
    endtask

    task automatic accept_cmd(input string tag);
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        check({tag, ":valid_after_accept"}, 32'(bus.cmd_valid), 32'd0);
        check({tag, ":busy_after_accept"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_payload(input string tag, input bq_t q, input int pstart, input int len);
        for (int i = 0; i < len; i++) begin
            bus.pay_raddr = AW'(i);
            #1;
            check({tag, ":pay"}, 32'(bus.pay_rdata), 32'(q[pstart+i]));
        end
    endtask

    task automatic run_frame(input bq_t q, input string tag);
        int kind, len, pstart;
        int unsigned a0, e0;
        logic [1:0] code;
        logic [7:0] op;
        model(q, kind, code, op, len, pstart);
        a0 = ack_cnt;
        e0 = err_cnt;
        foreach (q[i]) send_byte(q[i]);
        repeat (2) @(negedge clk);
        #1;
        check({tag, ":acks"}, ack_cnt - a0, 32'(q.size()));
        check({tag, ":err_pulse_low"}, 32'(bus.err_pulse), 32'd0);
        if (kind == K_ERR) begin
            check({tag, ":err_count"}, err_cnt - e0, 32'd1);
            check({tag, ":err_code"}, 32'(last_code), 32'(code));
            check({tag, ":cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
            check({tag, ":busy"}, 32'(bus.busy), 32'd0);
        end else if (kind == K_CMD) begin
            check({tag, ":err_count"}, err_cnt - e0, 32'd0);
            check({tag, ":cmd_valid"}, 32'(bus.cmd_valid), 32'd1);
            check({tag, ":busy"}, 32'(bus.busy), 32'd1);
            check({tag, ":cmd_op"}, 32'(bus.cmd_op), 32'(op));
            check({tag, ":cmd_len"}, 32'(bus.cmd_len), 32'(len));
            check_payload(tag, q, pstart, len);
            accept_cmd(tag);
        end
    endtask

    task automatic rand_frame(output bq_t q);
        int g, mode, len;
        logic [7:0] b, x;
        q    = {};
        g    = $urandom_range(0, 3);
        mode = $urandom_range(0, 9);
        repeat (g) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            q.push_back(b);
        end
        q.push_back(8'hA5);
        b = 8'($urandom);
        q.push_back(b);
        x = b;
        if (mode >= 8) begin
            q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            repeat ($urandom_range(0, 2)) q.push_back(8'($urandom_range(0, 8'hA4)));
            return;
        end
        len = $urandom_range(0, MAX_LEN);
        q.push_back(8'(len));
        x ^= 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x ^= b;
        end
        if (mode >= 6) x ^= 8'($urandom_range(1, 255));
        q.push_back(x);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        int unsigned a0, e0;
        int n;
        logic [7:0] x;

        bus.rx_data   = 8'd0;
        bus.rx_ready  = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.pay_raddr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset:rx_ack", 32'(bus.rx_ack), 32'd0);
        check("reset:cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("reset:err_pulse", 32'(bus.err_pulse), 32'd0);
        check("reset:busy", 32'(bus.busy), 32'd0);
        check("reset:cmd_op", 32'(bus.cmd_op), 32'd0);
        check("reset:cmd_len", 32'(bus.cmd_len), 32'd0);
        check("reset:err_code", 32'(bus.err_code), 32'd0);

        q = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h02};
        run_frame(q, "good_frame");
        q = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame(q, "bad_checksum");
        q = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h07};
        run_frame(q, "zero_len_garbage");
        q = '{8'hA5, 8'h01, 8'h21, 8'h44, 8'h55};
        run_frame(q, "len_overflow");
        q = '{8'hA5, 8'h09, 8'h01, 8'hBE, 8'hB6};
        run_frame(q, "after_overflow");

        // Payload at exactly MAX_LEN bytes.
        q = '{8'hA5, 8'hC3, 8'(MAX_LEN)};
        x = 8'hC3 ^ 8'(MAX_LEN);
        for (int i = 0; i < MAX_LEN; i++) begin
            q.push_back(8'(i * 7 + 1));
            x ^= 8'(i * 7 + 1);
        end
        q.push_back(x);
        run_frame(q, "max_len");

        // Inter-byte timeout after the opcode byte.
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h01);
        n = 0;
        while (err_cnt == e0 && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("timeout:err_count", err_cnt - e0, 32'd1);
        check("timeout:err_code", 32'(last_code), 32'd3);
        check("timeout:latency", err_cyc - take_cyc, 32'(TMO));
        check("timeout:busy", 32'(bus.busy), 32'd0);

        // Backpressure: command held while uart_rx offers a byte.
        q = '{8'hA5, 8'h5A, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        x = 8'h5A ^ 8'h04 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        q.push_back(x);
        foreach (q[i]) send_byte(q[i]);
        @(negedge clk);
        bus.rx_data  = 8'h3C;
        bus.rx_ready = 1'b1;
        a0 = ack_cnt;
        repeat (50) @(negedge clk);
        #1;
        check("backpressure:acks", ack_cnt - a0, 32'd0);
        check("backpressure:cmd_valid", 32'(bus.cmd_valid), 32'd1);
        check("backpressure:cmd_op", 32'(bus.cmd_op), 32'h5A);
        check("backpressure:cmd_len", 32'(bus.cmd_len), 32'd4);
        check_payload("backpressure", q, 3, 4);
        bus.rx_ready = 1'b0;
        accept_cmd("backpressure");

        // Reset in the middle of a payload.
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h05);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e0 = err_cnt;
        check("midreset:rx_ack", 32'(bus.rx_ack), 32'd0);
        check("midreset:cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("midreset:err_pulse", 32'(bus.err_pulse), 32'd0);
        check("midreset:busy", 32'(bus.busy), 32'd0);
        check("midreset:cmd_op", 32'(bus.cmd_op), 32'd0);
        check("midreset:cmd_len", 32'(bus.cmd_len), 32'd0);
        check("midreset:err_code", 32'(bus.err_code), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        check("midreset:no_error", err_cnt - e0, 32'd0);

        for (int f = 0; f < 30; f++) begin
            rand_frame(q);
            run_frame(q, "random");
        end

        check("err_pulse_single_cycle", err_wide, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller between uart_rx and the crypto engine selector.
- Consumes bytes from uart_rx through the rx_ready/rx_ack handshake.
- Hunts for a sync byte, then assembles an opcode, length, payload and XOR checksum.
- Presents each validated command to the crypto datapath over a valid/ready handshake, with a random-access payload read port.
- Flags malformed frames and inter-byte timeouts.

Parameters:
MAX_LEN, 32, maximum payload bytes per frame (1..255).
TIMEOUT_CYCLES, 500000, clk cycles allowed between consecutive bytes inside a frame (10 ms at 50 MHz).
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  byte from uart_rx
rx_ready  in  1  uart_rx byte available (level, held until acked)
rx_ack  out  1  one-cycle byte-consume pulse to uart_rx
cmd_valid  out  1  validated command available
cmd_ready  in  1  crypto selector accepts command
cmd_op  out  8  opcode
cmd_len  out  $clog2(MAX_LEN+1)  payload length, 0..MAX_LEN
pay_raddr  in  $clog2(MAX_LEN)  payload read address
pay_rdata  out  8  payload byte at pay_raddr (combinational read)
err_pulse  out  1  one-cycle error strobe
err_code  out  2  1=checksum, 2=length, 3=timeout; valid with err_pulse, held until next error
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst high at posedge): state IDLE. rx_ack, cmd_valid, err_pulse, busy all 0. cmd_op, cmd_len, err_code all 0. Timeout counter 0. Payload buffer is not reset. Reset mid-frame or mid-ISSUE abandons the frame with no error.
- Byte consume rule:
  - A byte is taken at a posedge where rx_ready=1, rx_ack=0 and state is not ISSUE.
  - rx_ack is registered and high for exactly the following cycle.
  - The rx_ack=0 guard blocks double-consumption while uart_rx clears rx_ready.
  - One rx_ack per byte, always, including discarded bytes.
- States:
  - IDLE: a consumed byte equal to SYNC_BYTE -> OP. Any other byte is discarded silently.
  - OP: the byte is latched as the opcode and chk is initialised to the opcode -> LEN.
  - LEN:
    - Byte > MAX_LEN -> err code 2, -> IDLE.
    - Byte = 0 -> CHK.
    - Otherwise -> PAY; payload index = 0.
    - In all three cases, chk ^= byte.
  - PAY: buffer[idx] <= byte, chk ^= byte, idx++. After byte idx = len-1 -> CHK.
  - CHK:
    - Byte == chk -> ISSUE. cmd_op and cmd_len are updated and cmd_valid=1 from the next cycle (one cycle after the checksum byte is sampled).
    - Mismatch -> err code 1, -> IDLE.
  - ISSUE:
    - cmd_valid held high; cmd_op, cmd_len and the buffer stay stable and no bytes are consumed (backpressure).
    - On posedge with cmd_valid & cmd_ready: cmd_valid drops next cycle, -> IDLE.
- Timeout:
  - The counter clears on every consumed byte and on entry to OP.
  - It increments in OP, LEN, PAY and CHK only.
  - On reaching TIMEOUT_CYCLES-1 without a byte: err code 3, -> IDLE.
  - A byte consumed in the same cycle as expiry wins and the timeout is ignored.
- Errors: err_pulse is high for exactly one cycle, the cycle after the detecting edge. It is never asserted for IDLE garbage or for reset.
- pay_rdata: pay_rdata = buffer[pay_raddr]. Contents beyond cmd_len and addresses >= MAX_LEN are don't-care. The payload is valid only while cmd_valid=1.
- Checksum: 8-bit XOR over opcode, length and payload bytes. The sync byte is excluded.

Test Plan:
1. Good frame: rx bytes A5 01 03 11 22 33 02 -> 7 rx_ack pulses; cmd_valid=1, cmd_op=01, cmd_len=3; pay_rdata at addr 0/1/2 = 11/22/33; cmd_ready=1 -> cmd_valid=0 next cycle, busy=0.
2. Bad checksum: A5 01 03 11 22 33 03 -> err_pulse for one cycle with err_code=1; cmd_valid stays 0; state returns to IDLE.
3. Zero-length frame preceded by garbage: 00 FF A5 07 00 07 -> garbage consumed silently; cmd_valid with cmd_op=07, cmd_len=0.
4. Length overflow: A5 01 21 (33 > MAX_LEN) -> err_code=2 after LEN; following 44 55 discarded; a later valid frame is accepted.
5. Timeout (TIMEOUT_CYCLES=100): A5 01 then no bytes -> err_code=3 exactly 100 cycles after the OP byte's consume edge; busy=0 afterwards.
6. Backpressure and reset: hold cmd_ready=0 for 50 cycles while uart_rx holds rx_ready=1 -> rx_ack stays 0 and cmd outputs stay stable. Then pulse rst during PAY of a new frame -> all outputs return to 0 and no err_pulse.
